// File: rtl/fib_pwm_scheduler.sv
// fib_pwm_scheduler
// NUM_CH Fibonacci breathing-PWM channels share one WIDTH-bit adder.
// Each tick starts a round-robin sweep that advances one channel per clock.
// Optional feature macro: FIB_SCHED_TICK_QUEUE_EN adds a one-deep pending-tick
// flag, so a tick that arrives during a sweep is kept instead of dropped.
module fib_pwm_scheduler #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tick,
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [WIDTH-1:0]          cfg_limit,
    output logic [NUM_CH-1:0]         pwm_out,
    output logic                      busy,
    output logic                      tick_overrun,
    input  logic                      overrun_clr
);

    localparam int              PW      = $clog2(NUM_CH);
    localparam logic [PW-1:0]   LAST_CH = PW'(NUM_CH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    // Sequencer state
    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            overrun_q, overrun_d;
    logic            overrun_set;
`ifdef FIB_SCHED_TICK_QUEUE_EN
    logic            pend_q, pend_d;
`endif

    // Per-channel register file
    logic [WIDTH-1:0]  count_q    [NUM_CH];
    logic [WIDTH-1:0]  fib_curr_q [NUM_CH];
    logic [WIDTH-1:0]  fib_prev_q [NUM_CH];
    logic [WIDTH-1:0]  limit_q    [NUM_CH];
    logic [NUM_CH-1:0] phase_q;
    logic [NUM_CH-1:0] pwm_q;

    // Selected channel and its next state
    logic [WIDTH-1:0] cur_count, cur_fib, cur_prev, cur_limit;
    logic             cur_phase, cur_en;
    logic             at_top, grow, wrap;
    logic [WIDTH-1:0] add_a, add_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] nx_count, nx_fib, nx_prev;
    logic             nx_phase;

    logic             cfg_accept;
    logic [WIDTH-1:0] cfg_limit_eff;
    logic             sweep_we;

    assign busy          = (state_q == SWEEP);
    assign cfg_ready     = !busy;
    assign cfg_accept    = cfg_valid && cfg_ready;
    // A limit of zero would pin the channel forever; treat it as one.
    assign cfg_limit_eff = (cfg_limit == '0) ? WIDTH'(1) : cfg_limit;
    assign sweep_we      = (state_q == SWEEP);
    assign tick_overrun  = overrun_q;
    // Disabling a channel silences its pad at once; stored state waits for the sweep.
    assign pwm_out       = pwm_q & ch_en;

    // Sequencer registers: state, sweep pointer, sticky overrun, pending tick.
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking = here would make results depend on statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            overrun_q <= 1'b0;
`ifdef FIB_SCHED_TICK_QUEUE_EN
            pend_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            overrun_q <= overrun_d;
`ifdef FIB_SCHED_TICK_QUEUE_EN
            pend_q    <= pend_d;
`endif
        end
    end

    // Next-state logic: start on tick, walk channels, restart or drop extra ticks.
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        overrun_set = 1'b0;
`ifdef FIB_SCHED_TICK_QUEUE_EN
        pend_d      = pend_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            SWEEP: begin
                if (ptr_q == LAST_CH) begin
`ifdef FIB_SCHED_TICK_QUEUE_EN
                    // A queued tick (or one arriving now) chains the next sweep
                    // back-to-back; if both exist the new one stays queued.
                    if (pend_q || tick) begin
                        ptr_d  = '0;
                        pend_d = pend_q && tick;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d     = IDLE;
                    overrun_set = tick;
`endif
                end else begin
                    ptr_d = ptr_q + 1'b1;
`ifdef FIB_SCHED_TICK_QUEUE_EN
                    if (tick) begin
                        if (pend_q) overrun_set = 1'b1;
                        else        pend_d      = 1'b1;
                    end
`else
                    overrun_set = tick;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
        // Set wins over clear when both happen in the same cycle.
        if (overrun_set)      overrun_d = 1'b1;
        else if (overrun_clr) overrun_d = 1'b0;
        else                  overrun_d = overrun_q;
    end

    // Channel step for the channel under the pointer, built around the one adder.
    always_comb begin
        cur_count = count_q[ptr_q];
        cur_fib   = fib_curr_q[ptr_q];
        cur_prev  = fib_prev_q[ptr_q];
        cur_limit = limit_q[ptr_q];
        cur_phase = phase_q[ptr_q];
        cur_en    = ch_en[ptr_q];

        at_top = (cur_count == cur_fib);
        grow   = at_top && cur_phase;

        // Operand mux: grow the Fibonacci pair at the end of LOW, else count up.
        add_a = grow ? cur_fib  : cur_count;
        add_b = grow ? cur_prev : WIDTH'(1);
        sum   = {1'b0, add_a} + {1'b0, add_b};
        wrap  = sum[WIDTH] || (sum[WIDTH-1:0] > cur_limit);

        nx_count = cur_count;
        nx_fib   = cur_fib;
        nx_prev  = cur_prev;
        nx_phase = cur_phase;

        if (!cur_en) begin
            nx_count = '0;
            nx_fib   = WIDTH'(1);
            nx_prev  = '0;
            nx_phase = 1'b0;
        end else if (at_top) begin
            nx_count = '0;
            nx_phase = !cur_phase;
            if (cur_phase) begin
                if (wrap) begin
                    nx_fib  = WIDTH'(1);
                    nx_prev = '0;
                end else begin
                    nx_fib  = sum[WIDTH-1:0];
                    nx_prev = cur_fib;
                end
            end
        end else begin
            nx_count = sum[WIDTH-1:0];
        end
    end

    // Register file writes: config (only when idle) or the swept channel.
    // NOTE: the register file is built from flops, not a RAM macro, so it takes
    // the asynchronous reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i]    <= '0;
                fib_curr_q[i] <= WIDTH'(1);
                fib_prev_q[i] <= '0;
                limit_q[i]    <= '1;
            end
            phase_q <= '0;
            pwm_q   <= '0;
        end else if (cfg_accept) begin
            count_q[cfg_ch]    <= '0;
            fib_curr_q[cfg_ch] <= WIDTH'(1);
            fib_prev_q[cfg_ch] <= '0;
            limit_q[cfg_ch]    <= cfg_limit_eff;
            phase_q[cfg_ch]    <= 1'b0;
            pwm_q[cfg_ch]      <= 1'b1;
        end else if (sweep_we) begin
            count_q[ptr_q]    <= nx_count;
            fib_curr_q[ptr_q] <= nx_fib;
            fib_prev_q[ptr_q] <= nx_prev;
            phase_q[ptr_q]    <= nx_phase;
            pwm_q[ptr_q]      <= !nx_phase;
        end
    end

endmodule

// File: doc/fib_pwm_scheduler.md
# fib_pwm_scheduler

Time-multiplexed controller that runs NUM_CH independent Fibonacci breathing-PWM channels through one shared WIDTH-bit adder. Each channel's count, Fibonacci pair and phase live in a per-channel register file. On every `tick` the block sweeps all channels round-robin, one channel per clock, advancing each channel one breathing step. It sits between the LED tick generator and the pad drivers and replaces one adder-per-channel instances of the breathing PWM core.

## Interface
- NUM_CH, 4, number of channels (2..16)
- WIDTH, 8, width of count, Fibonacci and limit values
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  single-cycle step strobe
- ch_en  in  NUM_CH  per-channel enable
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  configuration accepted when high with cfg_valid
- cfg_ch  in  $clog2(NUM_CH)  target channel
- cfg_limit  in  WIDTH  largest Fibonacci value allowed for the channel
- pwm_out  out  NUM_CH  registered PWM outputs
- busy  out  1  sweep in progress
- tick_overrun  out  1  sticky: a tick was lost
- overrun_clr  in  1  clears tick_overrun

One clock; reset is asynchronous and active-low.

## Operation
- Per-channel state: count, fib_curr, fib_prev, phase (0 = HIGH, 1 = LOW), limit.
- Reset and channel-reset values: count=0, fib_curr=1, fib_prev=0, phase=0. The reset value of limit is all ones.
- FSM states:
  - IDLE: leaves on an accepted tick and goes to SWEEP with ptr=0.
  - SWEEP: ptr increments each cycle. After ptr=NUM_CH-1 it returns to IDLE, or restarts at 0 if a queued tick exists (see Configuration).
- Channel step in SWEEP for channel ptr, using the single adder:
  - If ch_en[ptr]=0: the channel is forced to its reset values.
  - Else if count==fib_curr: count←0 and phase toggles.
    - If the old phase=1, the adder computes fib_curr+fib_prev at WIDTH+1 bits.
    - If the carry is set or sum>limit: fib_curr←1 and fib_prev←0.
    - Otherwise fib_curr←sum and fib_prev←fib_curr.
  - Else the adder computes count+1 and count←sum.
- Adder operand muxing: {fib_curr, fib_prev} when count==fib_curr and phase=1, otherwise {count, 1}. No second adder is permitted.
- pwm_out[i] = ch_en[i] AND phase[i]==0. It is registered and reflects channel state as last written.
- Config: cfg_ready = !busy. On cfg_valid && cfg_ready, limit[cfg_ch]←cfg_limit and that channel is reset to its reset values.
  - A cfg_limit of 0 behaves as 1.
  - Accepting a config in the same cycle as a tick is allowed. The config is applied first; the sweep starts next cycle.
- Overrun: tick_overrun is set when a tick is dropped and cleared by overrun_clr. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values: pwm_out=0, busy=0, tick_overrun=0, cfg_ready=1, all channel state at reset values.
- A tick sampled high at edge E while IDLE gives busy=1 after E. Channel k is updated at edge E+1+k.
- busy stays high exactly NUM_CH cycles per sweep.
- pwm_out[k] changes at the same edge its channel is updated.
- ch_en[k] deasserted drives pwm_out[k] to 0 combinationally. The stored state resets when channel k is next swept.
- Reset asserted mid-sweep returns all state to reset values asynchronously. A pending tick is discarded.
- HIGH and LOW phases each last fib_curr+1 ticks.

## Configuration
- FIB_SCHED_TICK_QUEUE_EN defined:
  - A one-deep pending-tick flag exists.
  - A tick while busy sets pending. The next sweep then starts immediately after the last channel, so busy stays high continuously.
  - A tick arriving while pending is already set is dropped and sets tick_overrun.
- FIB_SCHED_TICK_QUEUE_EN undefined:
  - There is no queue.
  - Any tick while busy is dropped and sets tick_overrun.

## Test plan
- Reset, ch_en=4'b0001, tick every 10 cycles, default limit: pwm_out[0] phase lengths in ticks are H2 L2 H2 L2 H3 L3 H4 L4 H6 L6 (fib_curr 1,1,2,3,5). pwm_out[3:1] stay 0.
- cfg_limit=8 on channel 2, ch_en=4'b0100: after fib_curr=8 (H9 L9), the sequence wraps to H2 L2 with fib_curr=1. The wrap on 8-bit carry with the default limit of 255 is checked separately (233+144 sets the carry).
- A tick asserted at E, then again at E+2: busy high for 4 cycles. Without the macro, tick_overrun=1. With the macro, tick_overrun=0 and busy is high for 8 consecutive cycles.
- ch_en[1] dropped mid-LOW phase: pwm_out[1] goes 0 at once. After re-enable, the channel restarts at H2 with fib_curr=1.
- cfg_valid held during a sweep: cfg_ready=0 until busy falls. The config is accepted in the first idle cycle, and the target channel restarts from reset values.
- rst_n pulsed low at ptr=2 of a sweep: all outputs return to reset values immediately, and the next tick starts a clean sweep at ptr=0.
